// File: rtl/writeback_queue.sv
// In-order writeback buffer: accepts up to two execution results per cycle and drains
// up to two per cycle onto the register unit's writeback ports.
module writeback_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = 3,
  parameter int unsigned regWidth  = 5,
  parameter int unsigned dataWidth = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 res1Valid_i,
  input  logic [regWidth-1:0]  res1Address_i,
  input  logic [dataWidth-1:0] res1Data_i,
  input  logic                 res2Valid_i,
  input  logic [regWidth-1:0]  res2Address_i,
  input  logic [dataWidth-1:0] res2Data_i,
  input  logic                 wbReady_i,
  output logic                 stall_o,
  output logic                 overflow_o,
  output logic                 reg1isWriteback_o,
  output logic [regWidth-1:0]  reg1WritebackAddress_o,
  output logic [dataWidth-1:0] reg1WritebackData_o,
  output logic                 reg2isWriteback_o,
  output logic [regWidth-1:0]  reg2WritebackAddress_o,
  output logic [dataWidth-1:0] reg2WritebackData_o,
  output logic [PTR_WIDTH:0]   count_o
);

  localparam int unsigned CntW = PTR_WIDTH + 1;
  localparam logic [CntW-1:0] StallLevel = CntW'(DEPTH - 2);

  logic [regWidth-1:0]  addr_mem [DEPTH];
  logic [dataWidth-1:0] data_mem [DEPTH];

  logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 stall_q, stall_d;
  logic                 overflow_q, overflow_d;

  logic                 wb1_valid_q, wb1_valid_d;
  logic [regWidth-1:0]  wb1_addr_q, wb1_addr_d;
  logic [dataWidth-1:0] wb1_data_q, wb1_data_d;
  logic                 wb2_valid_q, wb2_valid_d;
  logic [regWidth-1:0]  wb2_addr_q, wb2_addr_d;
  logic [dataWidth-1:0] wb2_data_q, wb2_data_d;

  logic [PTR_WIDTH-1:0] head_nxt;
  logic [PTR_WIDTH-1:0] wr2_idx;
  logic                 drain1, drain2;
  logic                 wr1, wr2;
  logic [CntW-1:0]      n_drain, n_enq;

  // Drain side: reads pre-edge memory contents, so same-edge slot reuse is safe.
  always_comb begin
    head_nxt = head_q + PTR_WIDTH'(1);
    drain1   = wbReady_i && (count_q != '0);
    // Same-address pair drains one at a time so the younger write lands last.
    drain2   = drain1 && (count_q >= CntW'(2)) && (addr_mem[head_nxt] != addr_mem[head_q]);
    n_drain  = CntW'(drain1) + CntW'(drain2);

    wb1_valid_d = drain1;
    wb1_addr_d  = wb1_addr_q;
    wb1_data_d  = wb1_data_q;
    wb2_valid_d = drain2;
    wb2_addr_d  = wb2_addr_q;
    wb2_data_d  = wb2_data_q;
    if (drain1) begin
      wb1_addr_d = addr_mem[head_q];
      wb1_data_d = data_mem[head_q];
    end
    if (drain2) begin
      wb2_addr_d = addr_mem[head_nxt];
      wb2_data_d = data_mem[head_nxt];
    end
  end

  // Enqueue side: a stalled cycle drops its results and flags overflow.
  always_comb begin
    wr1        = !stall_q && res1Valid_i;
    wr2        = !stall_q && res2Valid_i;
    wr2_idx    = wr1 ? tail_q + PTR_WIDTH'(1) : tail_q;
    n_enq      = CntW'(wr1) + CntW'(wr2);
    head_d     = head_q + PTR_WIDTH'(n_drain);
    tail_d     = tail_q + PTR_WIDTH'(n_enq);
    count_d    = count_q - n_drain + n_enq;
    stall_d    = count_d > StallLevel;
    overflow_d = overflow_q || (stall_q && (res1Valid_i || res2Valid_i));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      if (wr1) begin
        addr_mem[tail_q] <= res1Address_i;
        data_mem[tail_q] <= res1Data_i;
      end
      if (wr2) begin
        addr_mem[wr2_idx] <= res2Address_i;
        data_mem[wr2_idx] <= res2Data_i;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      stall_q     <= 1'b0;
      overflow_q  <= 1'b0;
      wb1_valid_q <= 1'b0;
      wb1_addr_q  <= '0;
      wb1_data_q  <= '0;
      wb2_valid_q <= 1'b0;
      wb2_addr_q  <= '0;
      wb2_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      overflow_q  <= overflow_d;
      wb1_valid_q <= wb1_valid_d;
      wb1_addr_q  <= wb1_addr_d;
      wb1_data_q  <= wb1_data_d;
      wb2_valid_q <= wb2_valid_d;
      wb2_addr_q  <= wb2_addr_d;
      wb2_data_q  <= wb2_data_d;
    end
  end

  assign stall_o                = stall_q;
  assign overflow_o             = overflow_q;
  assign reg1isWriteback_o      = wb1_valid_q;
  assign reg1WritebackAddress_o = wb1_addr_q;
  assign reg1WritebackData_o    = wb1_data_q;
  assign reg2isWriteback_o      = wb2_valid_q;
  assign reg2WritebackAddress_o = wb2_addr_q;
  assign reg2WritebackData_o    = wb2_data_q;
  assign count_o                = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus randomized traffic against a queue model.
module tb_writeback_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r1v, r2v, rdy;
  logic [4:0]  r1a, r2a;
  logic [63:0] r1d, r2d;

  logic        stall, ovf, v1, v2;
  logic [4:0]  a1, a2;
  logic [63:0] d1, d2;
  logic [3:0]  cnt;

  always #5 clk = ~clk;

  writeback_queue dut (
    .clock_i               (clk),
    .reset_i               (rst_n),
    .res1Valid_i           (r1v),
    .res1Address_i         (r1a),
    .res1Data_i            (r1d),
    .res2Valid_i           (r2v),
    .res2Address_i         (r2a),
    .res2Data_i            (r2d),
    .wbReady_i             (rdy),
    .stall_o               (stall),
    .overflow_o            (ovf),
    .reg1isWriteback_o     (v1),
    .reg1WritebackAddress_o(a1),
    .reg1WritebackData_o   (d1),
    .reg2isWriteback_o     (v2),
    .reg2WritebackAddress_o(a2),
    .reg2WritebackData_o   (d2),
    .count_o               (cnt)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  // Reference model: a plain queue of pending results plus the expected output values.
  ent_t        mq[$];
  logic        e_v1 = 0, e_v2 = 0, e_stall = 0, e_ovf = 0;
  logic [4:0]  e_a1 = 0, e_a2 = 0;
  logic [63:0] e_d1 = 0, e_d2 = 0;
  logic [3:0]  e_cnt = 0;

  wire [145:0] obs_vec = {stall, ovf, v1, a1, d1, v2, a2, d2, cnt};
  wire [145:0] exp_vec = {e_stall, e_ovf, e_v1, e_a1, e_d1, e_v2, e_a2, e_d2, e_cnt};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_edge(input logic rst, input logic iv1, input logic [4:0] ia1,
                            input logic [63:0] id1, input logic iv2, input logic [4:0] ia2,
                            input logic [63:0] id2, input logic irdy);
    logic old_stall;
    if (!rst) begin
      mq.delete();
      {e_v1, e_a1, e_d1, e_v2, e_a2, e_d2, e_stall, e_ovf, e_cnt} = '0;
    end else begin
      old_stall = e_stall;
      e_v1 = 1'b0;
      e_v2 = 1'b0;
      if (irdy && mq.size() >= 1) begin
        e_v1 = 1'b1;
        e_a1 = mq[0].a;
        e_d1 = mq[0].d;
        if (mq.size() >= 2 && mq[1].a != mq[0].a) begin
          e_v2 = 1'b1;
          e_a2 = mq[1].a;
          e_d2 = mq[1].d;
        end
        void'(mq.pop_front());
        if (e_v2) void'(mq.pop_front());
      end
      if (old_stall && (iv1 || iv2)) e_ovf = 1'b1;
      if (!old_stall) begin
        if (iv1) mq.push_back('{a: ia1, d: id1});
        if (iv2) mq.push_back('{a: ia2, d: id2});
      end
      e_cnt   = 4'(mq.size());
      e_stall = (DEPTH - int'(mq.size())) < 2;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, settle.
  task automatic cycle(input logic rst, input logic iv1, input logic [4:0] ia1,
                       input logic [63:0] id1, input logic iv2, input logic [4:0] ia2,
                       input logic [63:0] id2, input logic irdy);
    @(negedge clk);
    rst_n = rst; r1v = iv1; r1a = ia1; r1d = id1;
    r2v = iv2; r2a = ia2; r2d = id2; rdy = irdy;
    @(posedge clk);
    model_edge(rst, iv1, ia1, id1, iv2, ia2, id2, irdy);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 5'd9, 64'h1234, 1'b1, 5'd10, 64'h5678, 1'b1);
      n_checks++;
      if (obs_vec !== 146'b0) $display("FAIL reset_outputs got=%h want=0", obs_vec);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
    n_checks++;
    if ({v1, a1, d1, v2} !== {1'b1, 5'd5, 64'hDEAD, 1'b0})
      $display("FAIL single_port1 got=%b/%0d/%h/%b want=1/5/dead/0", v1, a1, d1, v2);
    else n_pass++;
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
    n_checks++;
    if ({v1, v2} !== 2'b00) $display("FAIL single_idle got=%b%b want=00", v1, v2);
    else n_pass++;
  endtask

  task automatic test_pair();
    cycle(1'b1, 1'b1, 5'd3, 64'd1, 1'b1, 5'd4, 64'd2, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
    n_checks++;
    if ({v1, a1, d1, v2, a2, d2, cnt} !== {1'b1, 5'd3, 64'd1, 1'b1, 5'd4, 64'd2, 4'd0})
      $display("FAIL pair_both_ports got=%h want=%h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_hazard();
    cycle(1'b1, 1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
    n_checks++;
    if ({v1, a1, d1, v2, cnt} !== {1'b1, 5'd7, 64'd1, 1'b0, 4'd1})
      $display("FAIL hazard_first got=%b/%0d/%0d/%b/%0d want=1/7/1/0/1", v1, a1, d1, v2, cnt);
    else n_pass++;
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
    n_checks++;
    if ({v1, a1, d1, v2} !== {1'b1, 5'd7, 64'd2, 1'b0})
      $display("FAIL hazard_second got=%b/%0d/%0d/%b want=1/7/2/0", v1, a1, d1, v2);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 5'(8 + 2 * i), 64'(100 + 2 * i),
            1'b1, 5'(9 + 2 * i), 64'(101 + 2 * i), 1'b0);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL fill_step%0d got=%h want=%h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if ({cnt, stall, ovf} !== {4'd8, 1'b1, 1'b0})
      $display("FAIL fill_full got=cnt%0d/st%b/ov%b want=8/1/0", cnt, stall, ovf);
    else n_pass++;
    cycle(1'b1, 1'b1, 5'd30, 64'hBAD, 1'b1, 5'd31, 64'hBAD, 1'b0);
    n_checks++;
    if ({cnt, stall, ovf} !== {4'd8, 1'b1, 1'b1})
      $display("FAIL fill_overflow got=cnt%0d/st%b/ov%b want=8/1/1", cnt, stall, ovf);
    else n_pass++;
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
    n_checks++;
    if ({cnt, stall, v1, a1, d1, v2, a2, d2} !==
        {4'd6, 1'b0, 1'b1, 5'd8, 64'd100, 1'b1, 5'd9, 64'd101})
      $display("FAIL fill_first_drain got=%h want=%h", obs_vec, exp_vec);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL fill_drain%0d got=%h want=%h", i, obs_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (cnt !== 4'd0) $display("FAIL fill_empty got=%0d want=0", cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 5'd1, 64'd11, 1'b1, 5'd2, 64'd12, 1'b0);
    cycle(1'b1, 1'b1, 5'd3, 64'd13, 1'b1, 5'd4, 64'd14, 1'b0);
    cycle(1'b1, 1'b1, 5'd5, 64'd15, 1'b0, 5'd0, 64'd0, 1'b0);
    n_checks++;
    if (cnt !== 4'd5) $display("FAIL resetmid_queued got=%0d want=5", cnt);
    else n_pass++;
    cycle(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    n_checks++;
    if (obs_vec !== 146'b0) $display("FAIL resetmid_cleared got=%h want=0", obs_vec);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1);
      n_checks++;
      if ({v1, v2, cnt} !== {1'b0, 1'b0, 4'd0})
        $display("FAIL resetmid_no_wb%0d got=%b%b/%0d want=00/0", i, v1, v2, cnt);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 5'(2 * i), $urandom, 1'b1, 5'(2 * i + 1), $urandom, 1'b1);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL b2b_%0d got=%h want=%h", i, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)), {$urandom, $urandom},
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0));
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL random_%0d got=%h want=%h", i, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; r1v = 1'b0; r2v = 1'b0; rdy = 1'b0;
    r1a = '0; r2a = '0; r1d = '0; r2d = '0;
    test_reset();
    test_single();
    test_pair();
    test_hazard();
    test_fill();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
